rom_reader: RTL and testbench

- Read initiator for the team's fixed-latency ROM responder, which samples RD on a CLK rising edge and returns data = addr + OFFSET after READ_LAT rising edges.
- Accepts a burst command (base address and word count) and issues one RD per word.
- Waits out the ROM latency, captures each word, and delivers it on a valid/ready output stream.
- Sits between a command source (CPU/DMA stub or bench) and the ROM.

---
 rtl/rom_pkg.sv | 24 ++
 rtl/rom_reader_if.sv | 30 +++
 rtl/rom_lat_counter.sv | 41 ++++
 rtl/rom_reader.sv | 180 ++++++++++++++++++
 tb/tb_rom_reader.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_pkg.sv
// Shared ROM constants: widths, latency and data offset agreed with the ROM
// responder, plus the reader FSM state encoding.
package rom_pkg;

  localparam int unsigned ROM_ADDR_W   = 8;
  localparam int unsigned ROM_DATA_W   = 8;
  localparam int unsigned ROM_READ_LAT = 3;
  localparam int unsigned ROM_OFFSET   = 1;

  typedef enum logic [2:0] {
    ST_QUIESCE = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_DONE    = 3'd5
  } rom_state_e;

  // Width needed to hold a latency count of v (at least one bit).
  function automatic int unsigned lat_cnt_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/rom_reader_if.sv
// Command, ROM bus and output stream of the ROM reader. The reader uses the
// master modport; the command source, ROM and sink side uses slave.
interface rom_reader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        count;
  logic              busy;
  logic              done;
  logic              RD;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base_addr, count, data, out_ready,
    output busy, done, RD, addr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, count, data, out_ready,
    input  busy, done, RD, addr, out_data, out_valid
  );

endinterface

// File: rtl/rom_lat_counter.sv
// Loadable down-counter with a registered zero flag; it resets to RST_VAL so
// the same counter times the post-reset quiesce and the ROM read latency.
module rom_lat_counter #(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned RST_VAL = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  // Load has priority; otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  // Count and flag registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= CNT_W'(RST_VAL);
      zero_q <= (RST_VAL == 0);
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/rom_reader.sv
// Burst read initiator for the fixed-latency ROM: issues one RD per word,
// waits out the latency, captures the word and offers it on a valid/ready
// stream. Optional data checking is built when ROM_READER_CHECK_EN is defined.
module rom_reader
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned READ_LAT = ROM_READ_LAT
`ifdef ROM_READER_CHECK_EN
  ,
  parameter int unsigned OFFSET   = ROM_OFFSET
`endif
) (
  input  logic         CLK,
  input  logic         RST_N,
  rom_reader_if.master bus
`ifdef ROM_READER_CHECK_EN
  ,
  output logic         err,
  output logic [7:0]   err_cnt
`endif
);

  localparam int unsigned CNT_W = lat_cnt_width(READ_LAT);

  rom_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rem_q, rem_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              rd_q, rd_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              lat_load_c;
  logic              lat_zero;
  logic              accept_c;
  logic              capture_c;

  // Shared latency timer: runs down the quiesce after reset, reloaded in ISSUE.
  rom_lat_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (READ_LAT)
  ) u_lat (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (lat_load_c),
    .load_val (CNT_W'(READ_LAT)),
    .zero     (lat_zero)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    lat_load_c = 1'b0;
    accept_c   = 1'b0;
    capture_c  = 1'b0;

    case (state_q)
      ST_QUIESCE: begin
        if (lat_zero) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          if (bus.count != 8'd0) begin
            addr_d  = bus.base_addr;
            rem_d   = bus.count;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        lat_load_c = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_zero) begin
          capture_c  = 1'b1;
          out_data_d = bus.data;
          state_d    = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          if (rem_q == 8'd1) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_q - 8'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_QUIESCE;
      end
    endcase

    rd_d        = (state_d == ST_ISSUE);
    out_valid_d = (state_d == ST_OUTPUT);
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset lands in QUIESCE with busy high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_QUIESCE;
      addr_q      <= '0;
      rem_q       <= 8'd0;
      out_data_q  <= '0;
      rd_q        <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.RD        = rd_q;
  assign bus.addr      = addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

`ifdef ROM_READER_CHECK_EN
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] exp_data_c;
  logic              mismatch_c;

  // Compare each captured word with addr+OFFSET; X/Z data counts as a miss.
  always_comb begin
    exp_data_c = DATA_W'(addr_q) + DATA_W'(OFFSET);
    mismatch_c = capture_c && (bus.data !== exp_data_c);
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    if (accept_c) begin
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end else if (mismatch_c) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Sticky error flag and saturating miss count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a fixed-latency ROM model
// (data = addr + OFFSET, READ_LAT edges after RD is sampled).
module tb_rom_reader;
  import rom_pkg::*;

  localparam int unsigned AW  = ROM_ADDR_W;
  localparam int unsigned DW  = ROM_DATA_W;
  localparam int unsigned LAT = ROM_READ_LAT;
  localparam int unsigned OFF = ROM_OFFSET;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ROM_READER_CHECK_EN
  logic       err;
  logic [7:0] err_cnt;
`endif

  rom_reader #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (LAT)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
`ifdef ROM_READER_CHECK_EN
    ,
    .err     (err),
    .err_cnt (err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // ROM responder model
  logic [AW-1:0] pa [LAT];
  logic          pv [LAT];
  logic [DW-1:0] rom_q   = '0;
  logic          corrupt = 1'b0;

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
  end

  always @(posedge CLK) begin
    if (pv[LAT-1]) rom_q <= DW'(pa[LAT-1]) + DW'(OFF);
    pv[0] <= (bus.RD === 1'b1);
    pa[0] <= bus.addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign bus.data = corrupt ? DW'(8'h55) : rom_q;

  // Event log sampled on every rising edge
  int            cyc = 0;
  int            done_cnt = 0;
  logic          prev_valid = 1'b0;
  logic [AW-1:0] rd_addr [$];
  int            rd_cyc [$];
  int            vrise_cyc [$];
  logic [DW-1:0] hs_data [$];

  always @(posedge CLK) begin
    cyc++;
    if (bus.RD === 1'b1) begin
      rd_addr.push_back(bus.addr);
      rd_cyc.push_back(cyc);
    end
    if (bus.out_valid === 1'b1 && prev_valid !== 1'b1) vrise_cyc.push_back(cyc);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_data.push_back(bus.out_data);
    if (bus.done === 1'b1) done_cnt++;
    prev_valid = bus.out_valid;
  end

  int vectors = 0;
  int errors  = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    rd_addr.delete();
    rd_cyc.delete();
    vrise_cyc.delete();
    hs_data.delete();
    done_cnt = 0;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [7:0] c);
    bus.base_addr = b;
    bus.count     = c;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      tick();
      n++;
    end
    vectors++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_done: no done pulse within %0d cycles (required one)", tag, max);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after_done: busy=%b required 0", tag, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_addr = '0; bus.count = 8'd0; bus.out_ready = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", bus.done); end
    vectors++; if (bus.RD !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b required 0", bus.RD); end
    vectors++; if (bus.addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h required 00", bus.addr); end
    vectors++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h required 00", bus.out_data); end
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    tick(); tick();
    RST_N = 1'b1;                      // cycle 0
    clear_log();
    tick();                            // cycle 1: start during quiesce
    start_burst(8'h20, 8'd1);          // now cycle 2
    vectors++; if (bus.busy !== 1'b1 || bus.addr !== 8'h00) begin errors++; $display("FAIL quiesce_c2: busy=%b addr=%h required busy=1 addr=00", bus.busy, bus.addr); end
    tick();                            // cycle 3
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL quiesce_c3: busy=%b required 1", bus.busy); end
    tick();                            // cycle 4
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL quiesce_c4: busy=%b required 0", bus.busy); end
    tick();                            // cycle 5: accepted start
    start_burst(8'h30, 8'd1);
    vectors++; if (bus.RD !== 1'b1 || bus.addr !== 8'h30) begin errors++; $display("FAIL post_rst_issue: RD=%b addr=%h required RD=1 addr=30", bus.RD, bus.addr); end
    wait_done("post_rst", 40);
    vectors++; if (rd_addr.size() != 1 || hs_data.size() != 1) begin errors++; $display("FAIL post_rst_counts: rd=%0d words=%0d required 1/1", rd_addr.size(), hs_data.size()); end
    else begin
      vectors++; if (hs_data[0] !== 8'h31) begin errors++; $display("FAIL post_rst_data: got %h required 31", hs_data[0]); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    logic [7:0] got;
    ea = '{8'h10, 8'h11, 8'h12};
    ed = '{8'h11, 8'h12, 8'h13};
    clear_log();
    bus.out_ready = 1'b1;
    start_burst(8'h10, 8'd3);
    wait_done("basic", 60);
    tick(); tick();
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rd_addr.size()) ? rd_addr[i] : 8'hxx;
      vectors++; if (got !== ea[i]) begin errors++; $display("FAIL basic_addr[%0d]: got %h required %h", i, got, ea[i]); end
      got = (i < hs_data.size()) ? hs_data[i] : 8'hxx;
      vectors++; if (got !== ed[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h required %h", i, got, ed[i]); end
    end
    vectors++;
    if (rd_cyc.size() != 3 || rd_cyc[1] - rd_cyc[0] != 6 || rd_cyc[2] - rd_cyc[1] != 6) begin
      errors++; $display("FAIL basic_rd_spacing: %0d RD pulses, required 3 spaced 6 cycles", rd_cyc.size());
    end
    vectors++;
    if (rd_cyc.size() < 1 || vrise_cyc.size() < 1 || vrise_cyc[0] - rd_cyc[0] != 5) begin
      errors++; $display("FAIL basic_latency: out_valid rise not 5 cycles after RD (rises=%0d)", vrise_cyc.size());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    logic [7:0] got;
    ea = '{8'hFE, 8'hFF, 8'h00};
    ed = '{8'hFF, 8'h00, 8'h01};
    clear_log();
    start_burst(8'hFE, 8'd3);
    wait_done("wrap", 60);
    for (int i = 0; i < 3; i++) begin
      got = (i < rd_addr.size()) ? rd_addr[i] : 8'hxx;
      vectors++; if (got !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, got, ea[i]); end
      got = (i < hs_data.size()) ? hs_data[i] : 8'hxx;
      vectors++; if (got !== ed[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h required %h", i, got, ed[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_log();
    bus.out_ready = 1'b0;
    start_burst(8'h10, 8'd2);
    while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: out_valid=%b required 1", bus.out_valid); end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h required 1/11", i, bus.out_valid, bus.out_data);
      end
      tick();
    end
    vectors++; if (rd_addr.size() != 1) begin errors++; $display("FAIL bp_no_second_rd: RD count %0d required 1", rd_addr.size()); end
    bus.out_ready = 1'b1;
    wait_done("bp", 40);
    vectors++;
    if (hs_data.size() != 2 || hs_data[0] !== 8'h11 || hs_data[1] !== 8'h12) begin
      errors++; $display("FAIL bp_data: %0d words, required 11,12", hs_data.size());
    end
    vectors++;
    if (rd_addr.size() != 2 || rd_addr[1] !== 8'h11) begin
      errors++; $display("FAIL bp_addr: %0d RDs, required 10,11", rd_addr.size());
    end
  endtask

  task automatic test_empty_and_busy();
    clear_log();
    start_burst(8'h40, 8'd0);
    vectors++; if (bus.done !== 1'b1) begin errors++; $display("FAIL empty_done: done=%b required 1", bus.done); end
    wait_done("empty", 5);
    tick(); tick();
    vectors++; if (rd_addr.size() != 0 || done_cnt != 1) begin errors++; $display("FAIL empty_counts: rd=%0d done=%0d required 0/1", rd_addr.size(), done_cnt); end

    clear_log();
    start_burst(8'h50, 8'd2);
    tick(); tick();
    start_burst(8'h99, 8'd5);
    vectors++; if (bus.addr !== 8'h50) begin errors++; $display("FAIL busy_start_addr: got %h required 50", bus.addr); end
    wait_done("busy_start", 60);
    repeat (8) tick();
    vectors++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 8'h50 || rd_addr[1] !== 8'h51) begin
      errors++; $display("FAIL busy_start_rd: %0d RDs, required 50,51", rd_addr.size());
    end
    vectors++;
    if (hs_data.size() != 2 || hs_data[0] !== 8'h51 || hs_data[1] !== 8'h52 || done_cnt != 1) begin
      errors++; $display("FAIL busy_start_words: %0d words done=%0d, required 51,52 and one done", hs_data.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    start_burst(8'h10, 8'd3);
    while (rd_addr.size() < 2 && n < 40) begin tick(); n++; end
    tick();                            // in WAIT of word 2
    RST_N = 1'b0;
    #1;
    vectors++;
    if (bus.RD !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.addr !== 8'h00) begin
      errors++; $display("FAIL mid_rst_outputs: RD=%b valid=%b busy=%b addr=%h required 0/0/1/00", bus.RD, bus.out_valid, bus.busy, bus.addr);
    end
    tick();
    RST_N = 1'b1;
    repeat (5) tick();
    vectors++; if (done_cnt != 0) begin errors++; $display("FAIL mid_rst_no_done: got %0d done pulses required 0", done_cnt); end

    clear_log();
    bus.out_ready = 1'b0;
    start_burst(8'h60, 8'd1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    #2 RST_N = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_valid_drop: out_valid=%b required 0", bus.out_valid); end
    tick();
    RST_N = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    vectors++; if (done_cnt != 0 || hs_data.size() != 0) begin errors++; $display("FAIL async_rst_no_done: done=%0d words=%0d required 0/0", done_cnt, hs_data.size()); end

    clear_log();
    start_burst(8'h20, 8'd2);
    wait_done("after_rst", 60);
    vectors++;
    if (hs_data.size() != 2 || hs_data[0] !== 8'h21 || hs_data[1] !== 8'h22) begin
      errors++; $display("FAIL after_rst_data: %0d words, required 21,22", hs_data.size());
    end
    vectors++;
    if (rd_addr.size() != 2 || rd_addr[0] !== 8'h20 || rd_addr[1] !== 8'h21) begin
      errors++; $display("FAIL after_rst_addr: %0d RDs, required 20,21", rd_addr.size());
    end
  endtask

`ifdef ROM_READER_CHECK_EN
  task automatic test_check();
    vectors++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL chk_clean: err=%b cnt=%0d required 0/0", err, err_cnt); end
    clear_log();
    corrupt = 1'b1;
    start_burst(8'h10, 8'd1);
    wait_done("chk_bad", 40);
    corrupt = 1'b0;
    vectors++; if (err !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL chk_mismatch: err=%b cnt=%0d required 1/1", err, err_cnt); end
    vectors++; if (hs_data.size() != 1 || hs_data[0] !== 8'h55) begin errors++; $display("FAIL chk_word: %0d words, required one of 55", hs_data.size()); end
    start_burst(8'h30, 8'd1);
    vectors++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL chk_clear_on_accept: err=%b cnt=%0d required 0/0", err, err_cnt); end
    wait_done("chk_good", 40);
    vectors++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL chk_good_burst: err=%b cnt=%0d required 0/0", err, err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_empty_and_busy();
    test_reset_mid();
`ifdef ROM_READER_CHECK_EN
    test_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
